// File: rtl/pong_pkg.sv
// pong_pkg: paddle geometry, paddle FSM state encoding and the clamped step helper
// shared by the pong input stage and the display/collision block.
package pong_pkg;

    localparam int Y_W = 10;
    localparam logic [Y_W-1:0] Y_MAX   = 10'd430;
    localparam logic [Y_W-1:0] Y_RESET = 10'd215;
    localparam int PADDLE_H = 50;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    // One movement step; saturates at both ends so 10-bit arithmetic never wraps.
    function automatic logic [Y_W-1:0] step_y(input logic [Y_W-1:0] y, input logic dn);
        return dn ? ((y >= Y_MAX) ? Y_MAX : y + 1'b1) : ((y == '0) ? '0 : y - 1'b1);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: two-flop synchroniser for an active-low raw key followed by a
// counter that only flips the pressed flag after DEBOUNCE_CYCLES stable mismatches.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_n_i,
    output logic pressed_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          db_q, db_d, hit;

    always_comb begin
        hit   = (~sync_q[1] != db_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
        cnt_d = (~sync_q[1] == db_q || hit) ? '0 : cnt_q + 1'b1;
        db_d  = db_q ^ hit;
    end

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
            db_q   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], key_n_i};
            cnt_q  <= cnt_d;
            db_q   <= db_d;
        end

    assign pressed_o = db_q;

endmodule

// File: rtl/paddle_ctrl.sv
// paddle_ctrl: debounces the four paddle keys, generates the movement tick and
// runs a hold/auto-repeat FSM per player driving clamped paddle Y registers.
module paddle_ctrl
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int TICK_DIV        = 50000,
    parameter int REPEAT_DELAY    = 8
) (
    input  logic           iclk,
    input  logic           irst,
    input  logic [3:0]     iKEY,
    input  logic           iFreeze,
    output logic [Y_W-1:0] oPaddleY0,
    output logic [Y_W-1:0] oPaddleY1,
    output logic [3:0]     oKeyDb,
    output logic           oTick
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int RW = $clog2(REPEAT_DELAY + 1);

    logic [TW-1:0]         tick_q;
    logic [1:0][Y_W-1:0]   y_pos;

    // Tick keeps running through iFreeze so repeat timing stays periodic.
    assign oTick = tick_q == TW'(TICK_DIV - 1);

    always_ff @(posedge iclk or posedge irst)
        if (irst) tick_q <= '0;
        else      tick_q <= oTick ? '0 : tick_q + 1'b1;

    for (genvar g = 0; g < 4; g++) begin : g_key
        key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk_i    (iclk),
            .rst_i    (irst),
            .key_n_i  (iKEY[g]),
            .pressed_o(oKeyDb[g])
        );
    end

    for (genvar p = 0; p < 2; p++) begin : g_player
        logic           up, dn, req;
        logic [1:0]     st_q, st_d;
        logic           dir_q, dir_d;
        logic [RW-1:0]  rc_q, rc_d;
        logic [Y_W-1:0] y_q, y_d;

        assign up  = oKeyDb[3-2*p];
        assign dn  = oKeyDb[2-2*p];
        assign req = up ^ dn;

        always_comb begin
            st_d  = st_q;
            dir_d = dir_q;
            rc_d  = rc_q;
            y_d   = y_q;
            if (iFreeze) begin
                st_d = ST_IDLE;
            end else if (st_q == ST_IDLE) begin
                if (req) begin
                    y_d   = step_y(y_q, dn);
                    dir_d = dn;
                    rc_d  = '0;
                    st_d  = ST_DELAY;
                end
            end else if (!req || dn != dir_q) begin
                st_d = ST_IDLE;
            end else if (oTick) begin
                if (st_q == ST_REPEAT) begin
                    y_d = step_y(y_q, dir_q);
                end else begin
                    rc_d = rc_q + 1'b1;
                    st_d = (rc_q == RW'(REPEAT_DELAY - 1)) ? ST_REPEAT : ST_DELAY;
                end
            end
        end

        always_ff @(posedge iclk or posedge irst)
            if (irst) begin
                st_q  <= ST_IDLE;
                dir_q <= 1'b0;
                rc_q  <= '0;
                y_q   <= Y_RESET;
            end else begin
                st_q  <= st_d;
                dir_q <= dir_d;
                rc_q  <= rc_d;
                y_q   <= y_d;
            end

        assign y_pos[p] = y_q;
    end

    assign oPaddleY0 = y_pos[0];
    assign oPaddleY1 = y_pos[1];

endmodule
